// File: rtl/fp_mult_arbiter.sv
// fp_mult_arbiter: round-robin sharing of one registered fp_mult among NUM_REQ requesters.
// fp_mult flushes subnormal inputs and outputs to zero; ROUND 0=nearest-even 1=zero 2=+inf 3=-inf.
module fp_mult #(
    parameter int ROUND = 0
) (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_z,
    output logic [7:0]  o_status
);
    logic               w_s, w_nan, w_inf, w_zero, w_fin, w_hi, w_g, w_st, w_inx, w_up;
    logic               w_huge, w_tiny, w_ovf_inf;
    logic [47:0]        w_p;
    logic [22:0]        w_m;
    logic [23:0]        w_mr;
    logic signed [9:0]  w_e;
    assign w_s = i_a[31] ^ i_b[31];
    assign w_nan = (&i_a[30:23] && |i_a[22:0]) || (&i_b[30:23] && |i_b[22:0]) ||
                   (&i_a[30:23] && ~|i_b[30:23]) || (&i_b[30:23] && ~|i_a[30:23]);
    assign w_inf = &i_a[30:23] || &i_b[30:23];
    assign w_zero = ~|i_a[30:23] || ~|i_b[30:23];
    assign w_fin = !w_nan && !w_inf && !w_zero;
    assign w_p = 48'({1'b1, i_a[22:0]}) * 48'({1'b1, i_b[22:0]});
    assign w_hi = w_p[47];
    assign w_m = w_hi ? w_p[46:24] : w_p[45:23];
    assign w_g = w_hi ? w_p[23] : w_p[22];
    assign w_st = w_hi ? |w_p[22:0] : |w_p[21:0];
    assign w_inx = w_g | w_st;
    assign w_up = ROUND == 0 ? w_g & (w_st | w_m[0]) :
                  ROUND == 2 ? ~w_s & w_inx :
                  ROUND == 3 ? w_s & w_inx : 1'b0;
    // a carry out of the fraction means the mantissa rounded up to 2.0
    assign w_mr = {1'b0, w_m} + 24'(w_up);
    assign w_e = 10'(i_a[30:23]) + 10'(i_b[30:23]) - 10'sd127 + 10'(w_hi) + 10'(w_mr[23]);
    assign w_huge = w_e > 10'sd254;
    assign w_tiny = w_e < 10'sd1;
    assign w_ovf_inf = ROUND == 0 || (ROUND == 2 && !w_s) || (ROUND == 3 && w_s);
    assign o_z = w_nan  ? 32'h7FC0_0000 :
                 w_inf  ? {w_s, 31'h7F80_0000} :
                 w_zero ? {w_s, 31'h0} :
                 w_huge ? {w_s, w_ovf_inf ? 31'h7F80_0000 : 31'h7F7F_FFFF} :
                 w_tiny ? {w_s, 31'h0} : {w_s, w_e[7:0], w_mr[22:0]};
    assign o_status = {2'b00, w_fin && (w_inx || w_huge || w_tiny), w_fin && w_huge,
                       w_fin && w_tiny, w_nan, o_z[30:0] == 31'h7F80_0000, o_z[30:0] == 31'h0};
endmodule

module fp_mult_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ROUND = 0,
    localparam int IDW = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*32-1:0]  req_a,
    input  logic [NUM_REQ*32-1:0]  req_b,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [IDW-1:0]         resp_id,
    output logic [31:0]            resp_z,
    output logic [7:0]             resp_status,
    output logic                   busy
);
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
    state_t          r_state;
    logic [IDW-1:0]  r_ptr, r_op_id, r_resp_id, w_gnt, w_ptr_nxt;
    logic            w_gnt_vld, r_resp_valid;
    logic [31:0]     r_op_a, r_op_b, r_resp_z, w_z;
    logic [7:0]      r_resp_status, w_status;
    logic [31:0]     w_a [NUM_REQ];
    logic [31:0]     w_b [NUM_REQ];
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign w_a[i] = req_a[32*i +: 32];
        assign w_b[i] = req_b[32*i +: 32];
    end
    // descending scan so the lowest offset from r_ptr wins
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req_valid[IDW'((int'(r_ptr) + k) % NUM_REQ)]) begin
                w_gnt_vld = 1'b1;
                w_gnt = IDW'((int'(r_ptr) + k) % NUM_REQ);
            end
    end
    assign w_ptr_nxt = (int'(w_gnt) == NUM_REQ - 1) ? '0 : w_gnt + 1'b1;
    assign req_ready = (r_state == IDLE && w_gnt_vld) ? NUM_REQ'(1) << w_gnt : '0;
    assign busy = r_state != IDLE;
    assign resp_valid = r_resp_valid;
    assign resp_id = r_resp_id;
    assign resp_z = r_resp_z;
    assign resp_status = r_resp_status;
    fp_mult #(.ROUND(ROUND)) u_mult (
        .i_a(r_op_a), .i_b(r_op_b), .o_z(w_z), .o_status(w_status)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr <= '0;
            r_op_a <= '0;
            r_op_b <= '0;
            r_op_id <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id <= '0;
            r_resp_z <= '0;
            r_resp_status <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_gnt_vld) begin
                    r_op_a <= w_a[w_gnt];
                    r_op_b <= w_b[w_gnt];
                    r_op_id <= w_gnt;
                    r_ptr <= w_ptr_nxt;
                    r_state <= CALC;
                end
                CALC: begin
                    r_resp_z <= w_z;
                    r_resp_status <= w_status;
                    r_resp_id <= r_op_id;
                    r_resp_valid <= 1'b1;
                    r_state <= RESP;
                end
                RESP: if (resp_ready) begin
                    r_resp_valid <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_mult_arbiter.sv
// tb_fp_mult_arbiter: directed handshake, rounding, round-robin, backpressure and reset checks.
module tb_fp_mult_arbiter;
    logic         clk = 1'b0;
    logic         rst, resp_valid, resp_ready, busy;
    logic [3:0]   req_valid, req_ready;
    logic [127:0] req_a, req_b;
    logic [1:0]   resp_id;
    logic [31:0]  resp_z;
    logic [7:0]   resp_status;
    int           checks = 0;
    int           errors = 0;
    logic [31:0]  rr_a [4] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0001};
    logic [31:0]  rr_b [4] = '{32'h4000_0000, 32'h4000_0000, 32'hBF00_0000, 32'h3F80_0001};
    logic [31:0]  rr_z [4] = '{32'h4000_0000, 32'h4080_0000, 32'hBFC0_0000, 32'h3F80_0002};
    logic [7:0]   rr_s [4] = '{8'h00, 8'h00, 8'h00, 8'h20};

    fp_mult_arbiter #(.NUM_REQ(4), .ROUND(0)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_z(resp_z), .resp_status(resp_status), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int id, input logic [31:0] a, input logic [31:0] b);
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
    endtask

    task automatic single_op(input string tag, input int id, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] z, input logic [7:0] st);
        set_op(id, a, b);
        req_valid = 4'(1 << id);
        #1;
        chk({tag, "_ready"}, 32'(req_ready), 32'(1 << id));
        step();
        req_valid = 4'b0000;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_calc_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_calc_ready"}, 32'(req_ready), 32'd0);
        step();
        chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, "_z"}, resp_z, z);
        chk({tag, "_status"}, 32'(resp_status), 32'(st));
        chk({tag, "_id"}, 32'(resp_id), 32'(id));
        step();
        chk({tag, "_done_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_done_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        resp_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_id", 32'(resp_id), 32'd0);
        chk("rst_z", resp_z, 32'd0);
        chk("rst_status", 32'(resp_status), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);

        single_op("one_times_two", 0, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 8'h00);
        single_op("sign_round", 2, 32'h4040_0000, 32'hBF00_0000, 32'hBFC0_0000, 8'h00);
        single_op("wrap_overflow", 1, 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 8'h32);

        set_op(1, 32'h7F00_0000, 32'h7F00_0000);
        set_op(2, 32'h4040_0000, 32'hBF00_0000);
        set_op(3, 32'h3F80_0001, 32'h3F80_0001);
        req_valid = 4'b1110;
        resp_ready = 1'b0;
        #1;
        chk("skip_ptr2_ready", 32'(req_ready), 32'b0100);
        step();
        step();
        for (int n = 0; n < 5; n++) begin
            chk("bp_valid", 32'(resp_valid), 32'd1);
            chk("bp_z", resp_z, 32'hBFC0_0000);
            chk("bp_id", 32'(resp_id), 32'd2);
            chk("bp_ready", 32'(req_ready), 32'd0);
            step();
        end
        resp_ready = 1'b1;
        step();
        chk("bp_release_valid", 32'(resp_valid), 32'd0);
        chk("bp_release_ready", 32'(req_ready), 32'b1000);
        req_valid = 4'b0000;
        #1;
        chk("withdraw_busy", 32'(busy), 32'd0);
        chk("withdraw_ready", 32'(req_ready), 32'd0);

        single_op("underflow", 1, 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 8'h29);

        set_op(0, 32'h3F80_0000, 32'h4000_0000);
        req_valid = 4'b0001;
        step();
        chk("mid_rst_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        req_valid = 4'b0000;
        step();
        chk("mid_rst_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step();
        step();
        chk("mid_rst_dropped", 32'(resp_valid), 32'd0);

        for (int k = 0; k < 4; k++) set_op(k, rr_a[k], rr_b[k]);
        req_valid = 4'b1111;
        #1;
        for (int n = 0; n < 5; n++) begin
            chk("rr_grant", 32'(req_ready), 32'(1 << (n % 4)));
            step();
            chk("rr_calc_ready", 32'(req_ready), 32'd0);
            step();
            chk("rr_valid", 32'(resp_valid), 32'd1);
            chk("rr_id", 32'(resp_id), 32'(n % 4));
            chk("rr_z", resp_z, rr_z[n % 4]);
            chk("rr_status", 32'(resp_status), 32'(rr_s[n % 4]));
            step();
        end
        req_valid = 4'b0000;
        step();
        chk("end_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
